// File: rtl/uart_tx_arb_if.sv
// Signal bundle between the requesters, the arbiter and the shared UART transmitter.
// master = requester/transmitter side, slave = the arbiter.
interface uart_tx_arb_if #(
   parameter int num_req   = 4,
   parameter int data_bits = 8
);
   localparam int id_bits = $clog2(num_req);

   logic [num_req-1:0]           req_vld;
   logic [num_req*data_bits-1:0] req_data;
   logic [num_req-1:0]           req_mask;
   logic [num_req-1:0]           req_rdy;
   logic                         uart_data_vld;
   logic [data_bits-1:0]         uart_data;
   logic                         uart_active;
   logic [id_bits-1:0]           grant_id;
   logic                         busy;
   logic                         timeout_err;

   modport master (
      output req_vld, req_data, req_mask, uart_active,
      input  req_rdy, uart_data_vld, uart_data, grant_id, busy, timeout_err
   );

   modport slave (
      input  req_vld, req_data, req_mask, uart_active,
      output req_rdy, uart_data_vld, uart_data, grant_id, busy, timeout_err
   );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding one shared UART transmitter from num_req requesters,
// with a start timeout that re-strobes a character the transmitter failed to pick up.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | arbitrate; accept the winner's character (req_rdy pulse)
//   ISSUE      | strobe uart_data_vld for one cycle
//   WAIT_START | wait for uart_active to rise, re-issue after start_timeout
//   WAIT_DONE  | wait for uart_active to fall, then back to IDLE
module uart_tx_arb #(
   parameter int num_req       = 4,
   parameter int data_bits     = 8,
   parameter int start_timeout = 4
) (
   input  logic          clk,
   input  logic          rst,
   uart_tx_arb_if.slave  bus
);
   localparam int id_bits  = $clog2(num_req);
   localparam int tmo_bits = $clog2(start_timeout + 1);
   localparam logic [tmo_bits-1:0] tmo_last = tmo_bits'(start_timeout - 1);
   localparam logic [tmo_bits-1:0] tmo_max  = tmo_bits'(start_timeout);

   // 3-bit encoding leaves spare codes that the default branch recovers from
   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      ISSUE      = 3'd1,
      WAIT_START = 3'd2,
      WAIT_DONE  = 3'd3
   } state_t;

   state_t               state;
   logic [id_bits-1:0]   last_grant;
   logic [id_bits-1:0]   grant_q;
   logic [data_bits-1:0] data_q;
   logic [tmo_bits-1:0]  tmo_cnt;
   logic                 tmo_err_q;
   logic                 vld_q;
   logic                 busy_q;

   logic [num_req-1:0]   elig;
   logic [id_bits-1:0]   cand;
   logic [id_bits-1:0]   win_id;
   logic                 win_found;
   logic [data_bits-1:0] win_data;

   // Scan downward so the last hit is the nearest index after last_grant.
   always_comb begin
      elig      = bus.req_vld & bus.req_mask;
      cand      = '0;
      win_id    = '0;
      win_found = 1'b0;
      for (int k = num_req; k >= 1; k--) begin
         cand = id_bits'((int'(last_grant) + k) % num_req);
         if (elig[cand]) begin
            win_id    = cand;
            win_found = 1'b1;
         end
      end
   end

   always_comb begin
      win_data = '0;
      for (int i = 0; i < num_req; i++) begin
         if (win_id == id_bits'(i)) win_data = bus.req_data[i*data_bits +: data_bits];
      end
   end

   always_comb begin
      bus.req_rdy = '0;
      for (int i = 0; i < num_req; i++) begin
         bus.req_rdy[i] = !rst && (state == IDLE) && win_found && (win_id == id_bits'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= id_bits'(num_req - 1);
         grant_q    <= '0;
         data_q     <= '0;
         tmo_cnt    <= '0;
         tmo_err_q  <= 1'b0;
         vld_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         vld_q <= 1'b0;
         case (state)
            IDLE: begin
               if (win_found) begin
                  state      <= ISSUE;
                  last_grant <= win_id;
                  grant_q    <= win_id;
                  data_q     <= win_data;
                  vld_q      <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            ISSUE: begin
               state   <= WAIT_START;
               tmo_cnt <= '0;
            end
            WAIT_START: begin
               if (bus.uart_active) begin
                  state <= WAIT_DONE;
               end else if (tmo_cnt == tmo_last) begin
                  state     <= ISSUE;
                  vld_q     <= 1'b1;
                  tmo_err_q <= 1'b1;
               end else if (tmo_cnt != tmo_max) begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!bus.uart_active) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   // Strobe and busy are forced low while rst is held, not just after it.
   assign bus.uart_data_vld = vld_q & ~rst;
   assign bus.busy          = busy_q & ~rst;
   assign bus.uart_data     = data_q;
   assign bus.grant_id      = grant_q;
   assign bus.timeout_err   = tmo_err_q;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: vector table, directed corner sequences, and a random
// run checked against an event-level round-robin/timeout model.
module tb_uart_tx_arb;
   localparam int N   = 4;
   localparam int DW  = 8;
   localparam int TMO = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_tx_arb_if #(.num_req(N), .data_bits(DW)) bus ();

   uart_tx_arb #(.num_req(N), .data_bits(DW), .start_timeout(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int tests = 0;
   int fails = 0;

   // Stub transmitter: busy for stub_len cycles after taking a strobe, or ignores it.
   logic stub_drop;
   int   stub_len;
   int   stub_cnt;
   always @(posedge clk) begin
      if (rst) begin
         bus.uart_active <= 1'b0;
         stub_cnt        <= 0;
      end else if (bus.uart_active) begin
         if (stub_cnt <= 1) bus.uart_active <= 1'b0;
         else stub_cnt <= stub_cnt - 1;
      end else if (bus.uart_data_vld && !stub_drop) begin
         bus.uart_active <= 1'b1;
         stub_cnt        <= stub_len;
      end
   end

   typedef struct {
      logic [N-1:0]    vld;
      logic [N-1:0]    mask;
      logic [N*DW-1:0] data;
      logic [N-1:0]    exp_rdy;
      int              exp_grant;
      logic [DW-1:0]   exp_data;
   } vec_t;

   vec_t vecs[10];
   int   exp_rr[12] = '{0, 1, 2, 3, 0, 1, 2, 3, 1, 3, 1, 3};
   int   rdy_cnt[N];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      bus.req_vld = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (bus.busy && n < 40) begin
         tick();
         n++;
      end
      chk(name, bus.busy, 0);
   endtask

   function automatic int rr_pick(input logic [N-1:0] elig, input int ptr);
      for (int k = 1; k <= N; k++) begin
         if (elig[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic int onehot_idx(input logic [N-1:0] v);
      if ($countones(v) != 1) return -1;
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // model state and scratch
   bit            m_idle, m_wait_start, m_wait_done, m_err;
   int            m_ptr, m_grant, m_strobe_at, m_dl, win, g, cyc, fall, n;
   logic [DW-1:0] m_data;
   logic [N-1:0]  exp_rdy;
   logic          prev_act, just;

   initial begin
      vecs[0] = '{4'b0001, 4'b1111, 32'h4443_4241, 4'b0001, 0, 8'h41};
      vecs[1] = '{4'b1111, 4'b1111, 32'h1413_1211, 4'b0010, 1, 8'h12};
      vecs[2] = '{4'b1111, 4'b1010, 32'hA4A3_A2A1, 4'b1000, 3, 8'hA4};
      vecs[3] = '{4'b1111, 4'b1010, 32'h5A5B_5C5D, 4'b0010, 1, 8'h5C};
      vecs[4] = '{4'b0001, 4'b1111, 32'h0000_007E, 4'b0001, 0, 8'h7E};
      vecs[5] = '{4'b0001, 4'b1110, 32'hFFFF_FFFF, 4'b0000, 0, 8'h7E};
      vecs[6] = '{4'b0100, 4'b1111, 32'h00C3_0000, 4'b0100, 2, 8'hC3};
      vecs[7] = '{4'b0101, 4'b1111, 32'h0011_2233, 4'b0001, 0, 8'h33};
      vecs[8] = '{4'b1001, 4'b1111, 32'h9900_0088, 4'b1000, 3, 8'h99};
      vecs[9] = '{4'b1001, 4'b1111, 32'h9900_0088, 4'b0001, 0, 8'h88};

      stub_drop    = 1'b0;
      stub_len     = 3;
      bus.req_mask = 4'b1111;
      bus.req_data = '0;

      // reset behaviour, with requests pending
      rst         = 1'b1;
      bus.req_vld = 4'b1111;
      #1;
      chk("rst rdy", bus.req_rdy, 0);
      chk("rst vld", bus.uart_data_vld, 0);
      chk("rst busy", bus.busy, 0);
      tick();
      tick();
      chk("rst grant", bus.grant_id, 0);
      chk("rst data", bus.uart_data, 0);
      chk("rst err", bus.timeout_err, 0);
      chk("rst busy2", bus.busy, 0);
      bus.req_vld = '0;
      rst         = 1'b0;

      // vector table, one transaction per entry, pointer carried across entries
      for (int i = 0; i < 10; i++) begin
         bus.req_vld  = vecs[i].vld;
         bus.req_mask = vecs[i].mask;
         bus.req_data = vecs[i].data;
         #1;
         chk("tbl rdy", bus.req_rdy, vecs[i].exp_rdy);
         tick();
         if (vecs[i].exp_rdy != 0) begin
            chk("tbl vld", bus.uart_data_vld, 1);
            chk("tbl data", bus.uart_data, vecs[i].exp_data);
            chk("tbl grant", bus.grant_id, vecs[i].exp_grant);
            chk("tbl busy", bus.busy, 1);
            bus.req_vld  = '0;
            bus.req_data = ~vecs[i].data;
            tick();
            bus.req_vld  = 4'b1111;
            bus.req_mask = 4'b1111;
            #1;
            chk("tbl rdy busy", bus.req_rdy, 0);
            chk("tbl vld once", bus.uart_data_vld, 0);
            wait_idle("tbl idle bound");
            chk("tbl hold", bus.uart_data, vecs[i].exp_data);
         end else begin
            chk("tbl empty vld", bus.uart_data_vld, 0);
            chk("tbl empty busy", bus.busy, 0);
            chk("tbl empty grant", bus.grant_id, vecs[i].exp_grant);
            chk("tbl empty hold", bus.uart_data, vecs[i].exp_data);
         end
      end

      // start timeout: transmitter ignores the first strobe
      stub_drop    = 1'b1;
      bus.req_vld  = 4'b0001;
      bus.req_mask = 4'b1111;
      bus.req_data = 32'h0000_005A;
      #1;
      chk("tmo rdy", bus.req_rdy, 4'b0001);
      tick();
      chk("tmo vld1", bus.uart_data_vld, 1);
      chk("tmo err0", bus.timeout_err, 0);
      bus.req_vld  = '0;
      bus.req_data = '0;
      tick();
      n = 1;
      while (!bus.uart_data_vld && n < 12) begin
         chk("tmo no rdy", bus.req_rdy, 0);
         tick();
         n++;
      end
      chk("tmo gap", n, TMO + 1);
      chk("tmo data", bus.uart_data, 8'h5A);
      chk("tmo err1", bus.timeout_err, 1);
      stub_drop = 1'b0;
      tick();
      chk("tmo vld single", bus.uart_data_vld, 0);
      wait_idle("tmo idle bound");
      chk("tmo err sticky", bus.timeout_err, 1);

      // reset while the frame is in WAIT_DONE
      stub_len     = 6;
      bus.req_vld  = 4'b0001;
      bus.req_data = 32'h0000_0077;
      #1;
      chk("mid rdy", bus.req_rdy, 4'b0001);
      tick();
      bus.req_vld = '0;
      tick();
      tick();
      chk("mid active", bus.uart_active, 1);
      rst          = 1'b1;
      bus.req_vld  = 4'b0010;
      bus.req_data = 32'h0000_3C00;
      #1;
      chk("mid rst rdy", bus.req_rdy, 0);
      chk("mid rst vld", bus.uart_data_vld, 0);
      chk("mid rst busy", bus.busy, 0);
      tick();
      chk("mid grant0", bus.grant_id, 0);
      chk("mid data0", bus.uart_data, 0);
      chk("mid err0", bus.timeout_err, 0);
      chk("mid vld0", bus.uart_data_vld, 0);
      rst = 1'b0;
      #1;
      chk("mid post rdy", bus.req_rdy, 4'b0010);
      tick();
      chk("mid post grant", bus.grant_id, 1);
      chk("mid post vld", bus.uart_data_vld, 1);
      chk("mid post data", bus.uart_data, 8'h3C);
      bus.req_vld = '0;
      wait_idle("mid idle bound");

      // round robin, then mask 1010; also the IDLE gap after uart_active falls
      do_reset();
      stub_len     = 3;
      bus.req_vld  = 4'b1111;
      bus.req_mask = 4'b1111;
      bus.req_data = 32'h4443_4241;
      for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
      g        = 0;
      cyc      = 0;
      fall     = -1;
      prev_act = 1'b0;
      #1;
      while (g < 12 && cyc < 400) begin
         if (prev_act && !bus.uart_active) fall = cyc;
         prev_act = bus.uart_active;
         just     = (bus.req_rdy != 0);
         if (just) begin
            chk("rr grant", onehot_idx(bus.req_rdy), exp_rr[g]);
            if (g > 0) chk("b2b gap", cyc - fall, 1);
            for (int i = 0; i < N; i++) if (bus.req_rdy[i]) rdy_cnt[i]++;
            g++;
         end
         tick();
         cyc++;
         if (just && g == 8) bus.req_mask = 4'b1010;
      end
      chk("rr count", g, 12);
      chk("rr cnt0", rdy_cnt[0], 2);
      chk("rr cnt1", rdy_cnt[1], 4);
      chk("rr cnt2", rdy_cnt[2], 2);
      chk("rr cnt3", rdy_cnt[3], 4);
      bus.req_vld = '0;
      wait_idle("rr idle bound");

      // random traffic against the event-level model
      do_reset();
      m_idle       = 1;
      m_wait_start = 0;
      m_wait_done  = 0;
      m_err        = 0;
      m_ptr        = N - 1;
      m_grant      = 0;
      m_strobe_at  = -1;
      m_dl         = 0;
      m_data       = '0;
      for (int c = 0; c < 3000; c++) begin
         bus.req_vld  = N'($urandom);
         bus.req_mask = N'($urandom);
         bus.req_data = $urandom;
         stub_len     = $urandom_range(1, 6);
         stub_drop    = ($urandom_range(0, 7) == 0);
         #1;
         exp_rdy = '0;
         win     = -1;
         if (m_idle) begin
            win = rr_pick(bus.req_vld & bus.req_mask, m_ptr);
            if (win >= 0) exp_rdy[win] = 1'b1;
         end
         chk("rnd rdy", bus.req_rdy, exp_rdy);
         chk("rnd vld", bus.uart_data_vld, (c == m_strobe_at));
         chk("rnd busy", bus.busy, !m_idle);
         chk("rnd grant", bus.grant_id, m_grant);
         chk("rnd err", bus.timeout_err, m_err);
         if (!m_idle) chk("rnd data", bus.uart_data, m_data);
         if (win >= 0) begin
            m_ptr       = win;
            m_grant     = win;
            m_data      = bus.req_data[win*DW +: DW];
            m_idle      = 0;
            m_strobe_at = c + 1;
         end else if (c == m_strobe_at) begin
            m_wait_start = 1;
            m_dl         = c + TMO;
         end else if (m_wait_start) begin
            if (bus.uart_active) begin
               m_wait_start = 0;
               m_wait_done  = 1;
            end else if (c == m_dl) begin
               m_wait_start = 0;
               m_err        = 1;
               m_strobe_at  = c + 1;
            end
         end else if (m_wait_done && !bus.uart_active) begin
            m_wait_done = 0;
            m_idle      = 1;
         end
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter num_req, default 4, giving the number of requesters (range 2-8).
REQ-002 The block SHALL have parameter data_bits, default 8, giving the character width (range 5-9).
REQ-003 The block SHALL have parameter start_timeout, default 4, giving the maximum number of cycles to wait for uart_active to rise after an issue.

Ports (name, direction, width, meaning):
REQ-004 clk, input, 1: clock; all logic SHALL be rising-edge.
REQ-005 rst, input, 1: reset, synchronous, active-high.
REQ-006 req_vld, input, num_req: per-requester character-valid flag.
REQ-007 req_data, input, num_req*data_bits: packed characters; requester i SHALL occupy bits [i*data_bits +: data_bits].
REQ-008 req_mask, input, num_req: per-requester enable; a 0 bit SHALL exclude that requester from arbitration.
REQ-009 req_rdy, output, num_req: one-hot accept pulse; bit i high SHALL mean requester i's character is taken this cycle.
REQ-010 uart_data_vld, output, 1: data-valid strobe to the shared transmitter.
REQ-011 uart_data, output, data_bits: character presented to the transmitter.
REQ-012 uart_active, input, 1: transmitter busy flag; high from the cycle after a strobe is accepted until the last stop bit ends.
REQ-013 grant_id, output, clog2(num_req): index of the current or most recent winner.
REQ-014 busy, output, 1: high in every state except IDLE.
REQ-015 timeout_err, output, 1: sticky flag, set when a start timeout occurs.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT_START and WAIT_DONE.
REQ-017 IDLE: eligible set SHALL be req_vld & req_mask; if the set is non-empty, the winner SHALL be the first eligible index searching upward from (last_grant+1) mod num_req, wrapping.
REQ-018 In the IDLE cycle with a winner, req_rdy[winner] SHALL be 1 (combinational); req_data of the winner, the winner index (into grant_id and last_grant) and the next state ISSUE SHALL be registered.
REQ-019 With an empty eligible set, the block SHALL stay in IDLE with req_rdy all zero.
REQ-020 req_rdy SHALL be zero in every state other than IDLE.
REQ-021 ISSUE: uart_data_vld SHALL be 1 for exactly this one cycle, with uart_data equal to the latched character; next state SHALL be WAIT_START.
REQ-022 uart_data SHALL hold the latched character from ISSUE until the next accept.
REQ-023 WAIT_START: uart_active=1 SHALL move the FSM to WAIT_DONE.
REQ-024 In WAIT_START, if uart_active stays 0 for start_timeout cycles, the FSM SHALL return to ISSUE, re-strobe the same character and set timeout_err.
REQ-025 WAIT_DONE: uart_active=0 SHALL move the FSM to IDLE; the next arbitration SHALL occur in that IDLE cycle.
REQ-026 Latency: request seen in IDLE at cycle T SHALL give req_rdy at T, uart_data_vld at T+1 and uart_active expected at T+2.
REQ-027 The minimum gap between characters SHALL be 1 IDLE cycle after uart_active falls.
REQ-028 Single eligible requester: it SHALL win every round; the pointer SHALL still advance to it.
REQ-029 req_vld deasserted after acceptance SHALL have no effect on the character in flight.
REQ-030 req_mask changes SHALL take effect at the next IDLE evaluation only.
REQ-031 The timeout counter SHALL be clog2(start_timeout+1) bits wide, cleared on entry to WAIT_START and saturating.
REQ-032 Illegal state encodings SHALL return the FSM to IDLE on the next cycle.

Reset
REQ-033 On rst, the FSM SHALL go to IDLE, last_grant SHALL be num_req-1 (so requester 0 has first priority), and grant_id, uart_data, the timeout counter and timeout_err SHALL be 0.
REQ-034 During and after reset, uart_data_vld and req_rdy SHALL be 0 and busy SHALL be 0.
REQ-035 rst asserted mid-transaction SHALL abandon the in-flight character; no req_rdy or strobe SHALL follow it.

Verification
REQ-036 Single request: req_vld=0001, data0=0x41, mask=1111 -> req_rdy=0001 at T; uart_data_vld=1 with uart_data=0x41 at T+1; busy until uart_active falls.
REQ-037 Round-robin: req_vld=1111 held with a stub transmitter -> grant order 0,1,2,3,0; each requester receives exactly one req_rdy per 4 characters.
REQ-038 Mask: req_vld=1111, mask=1010 -> grants alternate 1,3,1,3; requesters 0 and 2 never see req_rdy.
REQ-039 Timeout: stub holds uart_active=0 after the strobe -> after 4 cycles a second strobe with the same data; timeout_err=1 and stays set until rst.
REQ-040 Reset mid-frame: rst in WAIT_DONE -> IDLE next cycle with all outputs 0; after rst release with req_vld=0010, requester 1 is granted.
REQ-041 Back-to-back: req_vld=0001 held continuously -> exactly one IDLE cycle between uart_active falling and the next req_rdy.
